// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 64-bit ARM datapath.
// Also holds the architectural NZCV flags and an executed-instruction counter.
module ex_mem_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [63:0]      alu_result,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_cout,
    input  logic             set_flags,
    input  logic             is_logic,
    input  logic [63:0]      store_data,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             out_valid,
    output logic [63:0]      out_result,
    output logic [63:0]      out_store_data,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [3:0]       flags,
    output logic [3:0]       flags_fwd,
    output logic [CNT_W-1:0] exec_count
);

    logic       cap;
    logic [3:0] flags_new;

    assign cap       = in_valid & ~stall & ~flush;
    // Logical ops (ANDS) clear C and V; arithmetic ops take them from the ALU.
    assign flags_new = {alu_neg, alu_zero, alu_cout & ~is_logic, alu_ovf & ~is_logic};
    // Forward view lets a B.cond directly behind a flag-setter resolve without a bubble.
    assign flags_fwd = (in_valid & set_flags) ? flags_new : flags;

    // Stage register: flush squashes to a zeroed bubble, stall holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
        end else if (!stall) begin
            out_valid      <= in_valid;
            out_result     <= alu_result;
            out_store_data <= store_data;
            out_rd         <= rd;
            out_reg_write  <= in_valid & reg_write & (rd != 5'd31);
            out_mem_read   <= in_valid & mem_read;
            out_mem_write  <= in_valid & mem_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (cap && set_flags) begin
            flags <= flags_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_count <= '0;
        end else if (cap) begin
            exec_count <= exec_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [63:0] alu_result = '0, store_data = '0;
    logic        alu_neg = 1'b0, alu_zero = 1'b0, alu_ovf = 1'b0, alu_cout = 1'b0;
    logic        set_flags = 1'b0, is_logic = 1'b0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;

    logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [63:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  flags, flags_fwd;
    logic [31:0] exec_count;

    logic        o4_valid, o4_rw, o4_mr, o4_mw;
    logic [63:0] o4_result, o4_sd;
    logic [4:0]  o4_rd;
    logic [3:0]  o4_flags, o4_fwd;
    logic [3:0]  o4_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_cout(alu_cout), .set_flags(set_flags), .is_logic(is_logic),
        .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .out_valid(out_valid), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .flags(flags),
        .flags_fwd(flags_fwd), .exec_count(exec_count)
    );

    ex_mem_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_cout(alu_cout), .set_flags(set_flags), .is_logic(is_logic),
        .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .out_valid(o4_valid), .out_result(o4_result),
        .out_store_data(o4_sd), .out_rd(o4_rd), .out_reg_write(o4_rw),
        .out_mem_read(o4_mr), .out_mem_write(o4_mw), .flags(o4_flags),
        .flags_fwd(o4_fwd), .exec_count(o4_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [63:0] m_result, m_sd;
    logic [4:0]  m_rd;
    logic [3:0]  m_flags;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;

    function automatic logic [3:0] model_flags();
        logic c, v;
        c = is_logic ? 1'b0 : alu_cout;
        v = is_logic ? 1'b0 : alu_ovf;
        return {alu_neg, alu_zero, c, v};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_result = 0; m_sd = 0; m_rd = 0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_flags = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (in_valid && !stall && !flush) begin
                if (set_flags) m_flags = model_flags();
                m_cnt  = m_cnt + 1;
                m_cnt4 = 4'((m_cnt4 + 1) % 16);
            end
            if (flush) begin
                m_valid = 0; m_result = 0; m_sd = 0; m_rd = 0;
                m_rw = 0; m_mr = 0; m_mw = 0;
            end else if (!stall) begin
                m_valid  = in_valid;
                m_result = alu_result;
                m_sd     = store_data;
                m_rd     = rd;
                m_rw     = in_valid && reg_write && (rd != 31);
                m_mr     = in_valid && mem_read;
                m_mw     = in_valid && mem_write;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",     out_valid,      m_valid);
            chk("result",    out_result,     m_result);
            chk("store",     out_store_data, m_sd);
            chk("rd",        out_rd,         m_rd);
            chk("reg_write", out_reg_write,  m_rw);
            chk("mem_read",  out_mem_read,   m_mr);
            chk("mem_write", out_mem_write,  m_mw);
            chk("flags",     flags,          m_flags);
            chk("flags_fwd", flags_fwd, (in_valid && set_flags) ? model_flags() : m_flags);
            chk("count",     exec_count,     m_cnt);
            chk("count4",    o4_cnt,         m_cnt4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [63:0] res, input logic sf, input logic lg,
                          input logic n, input logic z, input logic c, input logic o);
        in_valid = v; alu_result = res; set_flags = sf; is_logic = lg;
        alu_neg = n; alu_zero = z; alu_cout = c; alu_ovf = o;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        reset = 1'b0;

        // Load all-ones, then an asynchronous reset must clear it mid-cycle
        set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lit_ones", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        #2 reset = 1'b1;
        #1;
        chk("lit_async_rst_result", out_result, 64'h0);
        chk("lit_async_rst_count", exec_count, 32'd0);
        tick();
        reset = 1'b0;

        // ADDS producing zero with carry
        set_op(1, 64'h0, 1, 0, 0, 1, 1, 0);
        rd = 5'd1; reg_write = 1'b1;
        tick();
        chk("lit_adds_flags", flags, 4'b0110);
        chk("lit_adds_valid", out_valid, 1'b1);
        chk("lit_adds_count", exec_count, 32'd1);

        // Stall holds everything for three edges, release loads
        stall = 1'b1;
        set_op(1, 64'h1234, 1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_result", out_result, 64'h0);
            chk("lit_stall_flags", flags, 4'b0110);
            chk("lit_stall_count", exec_count, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("lit_release_result", out_result, 64'h1234);
        chk("lit_release_flags", flags, 4'b1010);
        chk("lit_release_count", exec_count, 32'd2);

        // Flush beats stall
        flush = 1'b1; stall = 1'b1; mem_write = 1'b1;
        set_op(1, 64'h55, 1, 0, 1, 0, 0, 0);
        tick();
        chk("lit_flush_valid", out_valid, 1'b0);
        chk("lit_flush_rw", out_reg_write, 1'b0);
        chk("lit_flush_mw", out_mem_write, 1'b0);
        chk("lit_flush_result", out_result, 64'h0);
        chk("lit_flush_flags", flags, 4'b1010);
        chk("lit_flush_count", exec_count, 32'd2);
        flush = 1'b0; stall = 1'b0; mem_write = 1'b0;

        // ANDS: C and V cleared, visible on flags_fwd before the edge
        set_op(1, 64'h8000_0000_0000_0000, 1, 1, 1, 0, 1, 1);
        #1;
        chk("lit_ands_fwd", flags_fwd, 4'b1000);
        chk("lit_ands_before", flags, 4'b1010);
        tick();
        chk("lit_ands_flags", flags, 4'b1000);

        // XZR
        set_op(1, 64'h77, 0, 0, 0, 0, 0, 0);
        reg_write = 1'b1; rd = 5'd31;
        tick();
        chk("lit_xzr_rw", out_reg_write, 1'b0);
        chk("lit_xzr_rd", out_rd, 5'd31);
        rd = 5'd30;
        tick();
        chk("lit_x30_rw", out_reg_write, 1'b1);
        chk("lit_x30_rd", out_rd, 5'd30);

        // Counter wrap on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_op(1, 64'h1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick();
        chk("lit_wrap_count4", o4_cnt, 4'd1);
        chk("lit_wrap_count32", exec_count, 32'd17);
        in_valid = 1'b0; mem_read = 1'b1; reg_write = 1'b1;
        tick();
        chk("lit_bubble_valid", out_valid, 1'b0);
        chk("lit_bubble_mr", out_mem_read, 1'b0);
        chk("lit_bubble_rw", out_reg_write, 1'b0);
        chk("lit_bubble_count4", o4_cnt, 4'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            in_valid   = ($urandom_range(0, 4) != 0);
            alu_result = {$urandom, $urandom};
            store_data = {$urandom, $urandom};
            alu_neg    = 1'($urandom);
            alu_zero   = 1'($urandom);
            alu_ovf    = 1'($urandom);
            alu_cout   = 1'($urandom);
            set_flags  = 1'($urandom);
            is_logic   = 1'($urandom);
            rd         = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
            reg_write  = 1'($urandom);
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the 64-bit ALU (execute) and the data-memory stage of the 5-stage ARM datapath.
- Captures the ALU result, store data and destination/control bits.
- Owns the architectural NZCV flag register.
- Counts retired-from-execute instructions for performance monitoring.

Parameters:
- CNT_W, 32, width of the executed-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all stage registers, flags and counter this cycle
- flush  input  1  squash the instruction being captured this cycle
- in_valid  input  1  execute stage holds a real instruction
- alu_result  input  64  ALU result output
- alu_neg, alu_zero, alu_ovf, alu_cout  input  1 each  ALU flag outputs
- set_flags  input  1  instruction updates NZCV (ADDS/SUBS/ANDS)
- is_logic  input  1  flag-setting instruction is logical (ANDS): C and V are written 0
- store_data  input  64  register value for STUR
- rd  input  5  destination register index
- reg_write, mem_read, mem_write  input  1 each  control bits for later stages
- out_valid  output  1  registered valid
- out_result  output  64  registered alu_result
- out_store_data  output  64  registered store_data
- out_rd  output  5  registered rd
- out_reg_write, out_mem_read, out_mem_write  output  1 each  registered control
- flags  output  4  architectural {N,Z,C,V}, registered
- flags_fwd  output  4  combinational next-flag view for B.cond in execute
- exec_count  output  CNT_W  number of valid instructions captured

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high. While reset is high, every output register is 0: out_valid, out_result, out_store_data, out_rd, the three control bits, flags and exec_count. flags_fwd then follows the combinational rule below.
- Capture condition: cap = in_valid & ~stall & ~flush. Latency is 1 cycle: inputs present at edge k appear on outputs after edge k.
- Priority at each rising edge is flush > stall > normal.
  - flush: out_valid, out_reg_write, out_mem_read and out_mem_write go to 0; out_result, out_store_data and out_rd go to 0; flags hold; exec_count holds. Flush overrides a simultaneous stall.
  - stall (no flush): every register holds, including flags and exec_count.
  - normal: all stage registers load their inputs, with out_valid = in_valid. When in_valid=0, the control bits are forced to 0 (bubble).
- XZR rule: if rd==31, out_reg_write is forced 0 regardless of reg_write. out_rd still records 31.
- Flag update on cap & set_flags:
  - N = alu_neg, Z = alu_zero.
  - C = alu_cout & ~is_logic, V = alu_ovf & ~is_logic.
  - Otherwise flags hold. Flags are never cleared by flush.
- flags_fwd = the value flags would take at the next edge if cap & set_flags held (stall and flush ignored), else flags. This gives a branch directly behind an ADDS zero-bubble condition evaluation.
- exec_count increments by 1 on each edge where cap=1. It wraps from 2^CNT_W-1 to 0 with no sticky flag.
- Reset asserted mid-stall or mid-flush: all registers clear immediately; after deassertion, normal priority rules resume at the next edge.
- No combinational path from stall/flush to any output except through flags_fwd's dependence on the set_flags/in_valid inputs.

Test Plan:
- Reset, then capture: assert reset with out_result at 0xFFFF_FFFF_FFFF_FFFF, release, then capture ADDS with alu_result=0, alu_zero=1, alu_cout=1 -> outputs 0 immediately on reset; after the capture edge flags=4'b0110, out_valid=1, exec_count=1.
- Stall hold: hold stall for 3 cycles while inputs change to alu_result=0x1234 -> outputs, flags and exec_count unchanged for all 3 edges. The release edge loads 0x1234.
- Flush beats stall: assert flush and stall together with set_flags=1 and alu_neg=1 -> out_valid=0, control bits 0, flags unchanged, exec_count unchanged.
- Logical flags: ANDS with alu_neg=1, alu_cout=1, alu_ovf=1, is_logic=1 -> flags=4'b1000. flags_fwd shows 4'b1000 in the same cycle, before the edge.
- XZR: reg_write=1, rd=31 -> out_reg_write=0, out_rd=31. rd=30 -> out_reg_write=1.
- Counter wrap: CNT_W=4, 17 consecutive valid captures -> exec_count=1. A bubble (in_valid=0) in between does not increment the count and yields out_valid=0 with control bits 0.
